// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the button control unit.
//   - state_e     : run/stop/clear FSM encoding, also driven out on o_state
//   - DEF_*       : default clock and debounce sampling rates
//   - cnt_width() : width of a counter that must hold 0..max_val
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_SAMPLE_HZ   = 1_000;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEF_TICK_W = cnt_width(DEF_CLK_FREQ_HZ / DEF_SAMPLE_HZ - 1);

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   2-flop synchronizer -> DEB_DEPTH-deep shift register clocked by tick_i
//   -> debounced level (all ones sets, all zeros clears, else hold)
//   -> one-clock rising-edge pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_i      : one-clock sampling strobe shared by all buttons
//   btn_i       : raw button, asynchronous to clk
//   level_o     : debounced level
//   rise_o      : one clock high when level_o goes 0 -> 1
module btn_debounce #(
  parameter int unsigned DEB_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic                 sync1_q, sync2_q;
  logic [DEB_DEPTH-1:0] shift_q, shift_d;
  logic                 level_q, level_d;
  logic                 level_d1_q;

  // The level is judged on the shift register's next value so it moves on
  // the same edge as the qualifying sample, keeping latency minimal.
  always_comb begin
    // NOTE: defaults first -- every path assigns every output, so no latch is inferred.
    shift_d = shift_q;
    level_d = level_q;
    if (tick_i) shift_d = {shift_q[DEB_DEPTH-2:0], sync2_q};
    if (&shift_d)       level_d = 1'b1;
    else if (~|shift_d) level_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is reset too (it is state, not storage): a button held
    // through reset must re-qualify for DEB_DEPTH ticks and then yields exactly one rise.
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; this is what makes
      // sync1_q -> sync2_q a genuine two-stage synchronizer.
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      shift_q    <= shift_d;
      level_q    <= level_d;
      level_d1_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_d1_q;

endmodule

// File: rtl/btn_control_unit.sv
// btn_control_unit: control front end for the 4-digit FND up/down counter.
// Three raw buttons are debounced into rise pulses that drive a run/stop/clear
// FSM and an up/down toggle.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   i_btn_run/clear/mode: raw active-high buttons, asynchronous to clk
//   o_run               : 1 = counter counts (state RUN)
//   o_clear             : one-clock pulse (state CLEAR)
//   o_updown            : 0 = up, 1 = down; toggled by the mode button
//   o_state             : 00 STOP, 01 RUN, 10 CLEAR
// Build option: define BTN_LONG_PRESS_CLEAR_EN to let a run button held for
// LONG_PRESS_MS force a CLEAR (LONG_PRESS_MS*SAMPLE_HZ/1000 must be >= 1).
module btn_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
  parameter int unsigned SAMPLE_HZ     = DEF_SAMPLE_HZ,
  parameter int unsigned DEB_DEPTH     = 8,
  parameter int unsigned LONG_PRESS_MS = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_updown,
  output logic [1:0] o_state
);

  localparam int unsigned       TICK_DIV = CLK_FREQ_HZ / SAMPLE_HZ;
  localparam int unsigned       TICK_W   = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;
  logic              run_rise, clear_rise, mode_rise;
  logic              long_press;
  state_e            state_q;
  logic              updown_q;

  // Shared sampling strobe: one clock high every TICK_DIV clocks.
  assign tick = (tick_cnt_q == TICK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TICK_W'(1);
  end

`ifdef BTN_LONG_PRESS_CLEAR_EN
  logic run_level;
`endif

  btn_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_deb_run (
    .clk    (clk),
    .rst_n  (reset),
    .tick_i (tick),
    .btn_i  (i_btn_run),
`ifdef BTN_LONG_PRESS_CLEAR_EN
    .level_o(run_level),
`else
    .level_o(),
`endif
    .rise_o (run_rise)
  );

  btn_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_deb_clear (
    .clk    (clk),
    .rst_n  (reset),
    .tick_i (tick),
    .btn_i  (i_btn_clear),
    .level_o(),
    .rise_o (clear_rise)
  );

  btn_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_deb_mode (
    .clk    (clk),
    .rst_n  (reset),
    .tick_i (tick),
    .btn_i  (i_btn_mode),
    .level_o(),
    .rise_o (mode_rise)
  );

`ifdef BTN_LONG_PRESS_CLEAR_EN
  localparam int unsigned     LP_TICKS = LONG_PRESS_MS * SAMPLE_HZ / 1000;
  localparam int unsigned     LP_W     = cnt_width(LP_TICKS);
  localparam logic [LP_W-1:0] LP_MAX   = LP_W'(LP_TICKS);

  logic [LP_W-1:0] hold_q;
  logic            long_q;

  // Hold counter saturates at LP_MAX, so the event fires once per press;
  // releasing the button (debounced) rearms it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!run_level) begin
        hold_q <= '0;
      end else if (tick && hold_q != LP_MAX) begin
        hold_q <= hold_q + LP_W'(1);
        if (hold_q == LP_W'(LP_TICKS - 1)) long_q <= 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

  // Run/stop/clear FSM. Clear beats run in STOP; in RUN only run (or a long
  // press) acts; CLEAR always lasts exactly one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (clear_rise || long_press) state_q <= ST_CLEAR;
          else if (run_rise)            state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (long_press)    state_q <= ST_CLEAR;
          else if (run_rise) state_q <= ST_STOP;
        end
        default: state_q <= ST_STOP;
      endcase
    end
  end

  // Direction toggle runs beside the FSM and is never blocked by it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         updown_q <= 1'b0;
    else if (mode_rise) updown_q <= ~updown_q;
  end

  assign o_run    = (state_q == ST_RUN);
  assign o_clear  = (state_q == ST_CLEAR);
  assign o_updown = updown_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_btn_control_unit.sv
// tb_btn_control_unit: self-checking bench for btn_control_unit with a
// 10-clock tick and a 4-deep debouncer. Directed table, hand-written corner
// sequences and a randomized press sequence checked against a press-level model.
module tb_btn_control_unit;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned SMP_HZ   = 100;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LP_MS    = 100;
  localparam int          TICK_P   = CLK_HZ / SMP_HZ;          // 10 clocks
  localparam int          MAX_LAT  = 2 + DEPTH * TICK_P + 1;   // 43 clocks
  localparam int          LP_TICKS = LP_MS * SMP_HZ / 1000;    // 10 ticks
  localparam int          HOLD_MIN = 50;
  localparam int          HOLD_MAX = 80;
  localparam int          IDLE     = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_run, b_clear, b_mode;
  logic       o_run, o_clear, o_updown;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  btn_control_unit #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .SAMPLE_HZ    (SMP_HZ),
    .DEB_DEPTH    (DEPTH),
    .LONG_PRESS_MS(LP_MS)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .i_btn_run  (b_run),
    .i_btn_clear(b_clear),
    .i_btn_mode (b_mode),
    .o_run      (o_run),
    .o_clear    (o_clear),
    .o_updown   (o_updown),
    .o_state    (o_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Background monitors: clear pulse count, pulse width, illegal state.
  int   clear_pulses = 0;
  int   width_err    = 0;
  int   bad_state    = 0;
  logic clr_prev     = 1'b0;

  always @(negedge clk) begin
    if (o_clear === 1'b1) clear_pulses++;
    if (o_clear === 1'b1 && clr_prev === 1'b1) width_err++;
    if (o_state === 2'b11) bad_state++;
    clr_prev = o_clear;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Press a button set (mask = {mode, clear, run}), hold, release, settle.
  task automatic do_press(input logic [2:0] mask, input int hold);
    b_run   = mask[0];
    b_clear = mask[1];
    b_mode  = mask[2];
    repeat (hold) @(negedge clk);
    b_run   = 1'b0;
    b_clear = 1'b0;
    b_mode  = 1'b0;
    repeat (IDLE) @(negedge clk);
  endtask

  // Toggle one button every 7 clocks: never 4 equal samples 10 clocks apart.
  task automatic do_bounce(input int idx, input int len);
    logic v;
    for (int c = 0; c < len; c++) begin
      v = ((c / 7) % 2) == 0;
      b_run   = (idx == 0) ? v : 1'b0;
      b_clear = (idx == 1) ? v : 1'b0;
      b_mode  = (idx == 2) ? v : 1'b0;
      @(negedge clk);
    end
    b_run   = 1'b0;
    b_clear = 1'b0;
    b_mode  = 1'b0;
    repeat (IDLE) @(negedge clk);
  endtask

  task automatic check_settled(input string tag, input logic exp_run, input logic exp_ud,
                               input int exp_clr, input int clr_before);
    check({tag, ".run"},    o_run, exp_run);
    check({tag, ".updown"}, o_updown, exp_ud);
    check({tag, ".clears"}, clear_pulses - clr_before, exp_clr);
    check({tag, ".state"},  o_state, {1'b0, exp_run});
  endtask

  // Press-level reference model.
  logic m_run, m_ud;
  int   m_clr;
  task automatic model_press(input logic [2:0] mask);
    m_clr = 0;
    if (mask[2]) m_ud = ~m_ud;
    if (!m_run) begin
      if (mask[1])      m_clr = 1;
      else if (mask[0]) m_run = 1'b1;
    end else if (mask[0]) begin
      m_run = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0] mask;
    logic       exp_run;
    logic       exp_ud;
    int         exp_clr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int   first, clr0, n_clr_hi, seen_clear, seen_bad, t_run, t_clr;
    logic dropped, saw_run, saw_clear;

    vecs[0]  = '{3'b001, 1'b1, 1'b0, 0};  // run: STOP -> RUN
    vecs[1]  = '{3'b010, 1'b1, 1'b0, 0};  // clear ignored in RUN
    vecs[2]  = '{3'b100, 1'b1, 1'b1, 0};  // mode during RUN
    vecs[3]  = '{3'b001, 1'b0, 1'b1, 0};  // run: RUN -> STOP
    vecs[4]  = '{3'b010, 1'b0, 1'b1, 1};  // clear in STOP
    vecs[5]  = '{3'b011, 1'b0, 1'b1, 1};  // run+clear in STOP: clear wins
    vecs[6]  = '{3'b101, 1'b1, 1'b0, 0};  // run+mode in STOP
    vecs[7]  = '{3'b111, 1'b0, 1'b1, 0};  // all three in RUN -> STOP
    vecs[8]  = '{3'b110, 1'b0, 1'b0, 1};  // clear+mode in STOP
    vecs[9]  = '{3'b100, 1'b0, 1'b1, 0};  // mode in STOP
    vecs[10] = '{3'b101, 1'b1, 1'b0, 0};  // run+mode
    vecs[11] = '{3'b100, 1'b1, 1'b1, 0};  // leave RUN with updown=1

    // Reset held with buttons toggling.
    rst_n = 1'b0;
    b_run = 1'b0; b_clear = 1'b0; b_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_run   = i[0];
      b_clear = ~i[0];
      b_mode  = i[1];
      @(negedge clk);
      check($sformatf("reset_hold[%0d]", i), {o_run, o_clear, o_updown, o_state}, 0);
    end
    b_run = 1'b0; b_clear = 1'b0; b_mode = 1'b0;
    rst_n = 1'b1;
    repeat (IDLE) @(negedge clk);

    // Clean run press: latency bound and exactly one rise over 100 clocks.
    first = 0; dropped = 1'b0;
    b_run = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (o_run && first == 0) first = i;
      if (first != 0 && !o_run) dropped = 1'b1;
    end
    b_run = 1'b0;
    repeat (IDLE) @(negedge clk);
    check($sformatf("run_latency(%0d clk)", first), (first > 0 && first <= MAX_LAT), 1);
    check("run_single_rise", dropped, 0);
    check("run_level", o_run, 1);
    do_press(3'b001, 100);
    check("run_second_press_stops", o_run, 0);

    // Bounce rejection.
    saw_run = 1'b0;
    for (int c = 0; c < 60; c++) begin
      b_run = ((c / 7) % 2) == 0;
      @(negedge clk);
      if (o_run) saw_run = 1'b1;
    end
    b_run = 1'b0;
    for (int c = 0; c < IDLE; c++) begin
      @(negedge clk);
      if (o_run) saw_run = 1'b1;
    end
    check("bounce_no_run", saw_run, 0);

    // Clear in STOP: 00 -> 10 -> 00, exactly one clock of o_clear.
    n_clr_hi = 0; seen_clear = 0; seen_bad = 0;
    b_clear = 1'b1;
    for (int i = 0; i < 70 + IDLE; i++) begin
      if (i == 70) b_clear = 1'b0;
      @(negedge clk);
      if (o_clear) n_clr_hi++;
      if (o_state == 2'b10) seen_clear++;
      if (o_state == 2'b01 || o_state == 2'b11) seen_bad++;
    end
    check("clear_stop_width", n_clr_hi, 1);
    check("clear_stop_state10", seen_clear, 1);
    check("clear_stop_no_run", seen_bad, 0);
    check("clear_stop_final", o_state, 2'b00);

    // Clear in RUN is ignored.
    do_press(3'b001, 60);
    check("clear_run_setup", o_run, 1);
    saw_clear = 1'b0; dropped = 1'b0;
    b_clear = 1'b1;
    for (int i = 0; i < 70 + IDLE; i++) begin
      if (i == 70) b_clear = 1'b0;
      @(negedge clk);
      if (o_clear) saw_clear = 1'b1;
      if (!o_run) dropped = 1'b1;
    end
    check("clear_in_run_no_pulse", saw_clear, 0);
    check("clear_in_run_keeps_run", dropped, 0);
    do_press(3'b001, 60);
    check("stop_before_table", o_run, 0);

    // Directed table from STOP, updown=0.
    for (int v = 0; v < 12; v++) begin
      clr0 = clear_pulses;
      do_press(vecs[v].mask, 60);
      check_settled($sformatf("vec%0d", v), vecs[v].exp_run, vecs[v].exp_ud, vecs[v].exp_clr, clr0);
    end

    // Reset mid-operation (RUN, updown=1), run held through release.
    b_run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {o_run, o_clear, o_updown, o_state}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first = 0; dropped = 1'b0;
    for (int i = 1; i <= MAX_LAT + 100; i++) begin
      @(negedge clk);
      if (o_run && first == 0) first = i;
      if (first != 0 && !o_run) dropped = 1'b1;
    end
    check($sformatf("held_through_reset_latency(%0d clk)", first),
          (first > 2 + (DEPTH - 1) * TICK_P && first <= MAX_LAT), 1);
    check("held_through_reset_single_rise", dropped, 0);
    b_run = 1'b0;
    repeat (IDLE) @(negedge clk);
    do_press(3'b001, 60);
    check("stop_before_long", o_run, 0);

    // Long hold of the run button for 150 ticks.
    t_run = 0; t_clr = 0; clr0 = clear_pulses;
    b_run = 1'b1;
    for (int i = 1; i <= 150 * TICK_P; i++) begin
      @(negedge clk);
      if (o_run && t_run == 0) t_run = i;
      if (o_clear && t_clr == 0) t_clr = i;
    end
    check($sformatf("long_run_seen(%0d clk)", t_run), (t_run > 0 && t_run <= MAX_LAT), 1);
`ifdef BTN_LONG_PRESS_CLEAR_EN
    check("long_clear_count", clear_pulses - clr0, 1);
    check("long_clear_delay", t_clr - t_run, LP_TICKS * TICK_P);
    check("long_after_run", o_run, 0);
    check("long_after_state", o_state, 2'b00);
    b_run = 1'b0;
    repeat (IDLE) @(negedge clk);
`else
    check("long_no_clear", clear_pulses - clr0, 0);
    check("long_still_run", o_run, 1);
    b_run = 1'b0;
    repeat (IDLE) @(negedge clk);
    do_press(3'b001, 60);
    check("long_stop_after", o_run, 0);
`endif

    // Randomized presses and bounces against the model.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (IDLE) @(negedge clk);
    m_run = 1'b0; m_ud = 1'b0; m_clr = 0;
    for (int n = 0; n < 40; n++) begin
      clr0 = clear_pulses;
      if ($urandom_range(0, 4) == 0) begin
        m_clr = 0;
        do_bounce($urandom_range(0, 2), $urandom_range(20, 60));
      end else begin
        logic [2:0] mask;
        mask = 3'($urandom_range(1, 7));
        model_press(mask);
        do_press(mask, $urandom_range(HOLD_MIN, HOLD_MAX));
      end
      check_settled($sformatf("rand%0d", n), m_run, m_ud, m_clr, clr0);
    end

    check("clear_pulse_width_errors", width_err, 0);
    check("illegal_state_seen", bad_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
